// File: rtl/usb_sync_fifo.sv
// ============================================================================
//  Module   : usb_sync_fifo
//  Brief    : Single-clock FIFO for the USB PHY/SIE datapath; FWFT or
//             registered-pop read, level/almost flags, sticky error flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 6,
    parameter int FWFT       = 1,
    parameter int AFULL_THR  = 56,
    parameter int AEMPTY_THR = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  err_clr_i,
    output logic [DATA_W-1:0]     data_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  afull_o,
    output logic                  aempty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  ovf_o,
    output logic                  udf_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AFULL  = LVL_W'(AFULL_THR);
    localparam logic [LVL_W-1:0] LVL_AEMPTY = LVL_W'(AEMPTY_THR);

    generate
        if (DATA_W < 1 || DEPTH_LOG2 < 1 || DEPTH_LOG2 > 12 ||
            AEMPTY_THR >= AFULL_THR || AFULL_THR > DEPTH) begin : g_param_check
            $error("usb_sync_fifo: illegal parameter combination");
        end
    endgenerate

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LVL_W-1:0]      level;
    logic                  ovf;
    logic                  udf;

    logic wr_en;
    logic rd_en;
    logic ovf_set;
    logic udf_set;

    // A pop frees a slot in the same cycle, so push+pop while full is accepted.
    assign wr_en   = push_i & (~full_o | pop_i) & ~flush_i;
    assign rd_en   = pop_i & ~empty_o & ~flush_i;
    assign ovf_set = push_i & full_o & ~pop_i & ~flush_i;
    assign udf_set = pop_i & empty_o & ~flush_i;

    assign full_o   = (level == LVL_FULL);
    assign empty_o  = (level == '0);
    assign afull_o  = (level >= LVL_AFULL);
    assign aempty_o = (level <= LVL_AEMPTY);
    assign level_o  = level;
    assign ovf_o    = ovf;
    assign udf_o    = udf;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            if (wr_en && !rd_en) begin
                level <= level + LVL_W'(1);
            end else if (rd_en && !wr_en) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // A new error in the clearing cycle wins over the clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf_set | (ovf & ~err_clr_i);
            udf <= udf_set | (udf & ~err_clr_i);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_o  = empty_o ? '0 : mem[rd_ptr];
            assign valid_o = ~empty_o;
        end else begin : g_reg_pop
            logic [DATA_W-1:0] data_q;
            logic              valid_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_en;
                    if (rd_en) begin
                        data_q <= mem[rd_ptr];
                    end
                end
            end

            assign data_o  = data_q;
            assign valid_o = valid_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_usb_sync_fifo.sv
// ============================================================================
//  Module   : tb_usb_sync_fifo
//  Brief    : Directed and scoreboarded checks of usb_sync_fifo in FWFT and
//             registered-pop configurations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_sync_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: default parameters, FWFT
    logic       a_flush, a_push, a_pop, a_clr;
    logic [7:0] a_din, a_dout;
    logic       a_valid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
    logic [6:0] a_level;

    // Instance B: registered-pop, 16-bit, 4 entries
    logic        b_flush, b_push, b_pop, b_clr;
    logic [15:0] b_din, b_dout;
    logic        b_valid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
    logic [2:0]  b_level;

    usb_sync_fifo u_dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .data_i(a_din),
        .push_i(a_push), .pop_i(a_pop), .err_clr_i(a_clr), .data_o(a_dout),
        .valid_o(a_valid), .full_o(a_full), .empty_o(a_empty), .afull_o(a_afull),
        .aempty_o(a_aempty), .level_o(a_level), .ovf_o(a_ovf), .udf_o(a_udf)
    );

    usb_sync_fifo #(
        .DATA_W(16), .DEPTH_LOG2(2), .FWFT(0), .AFULL_THR(3), .AEMPTY_THR(1)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .data_i(b_din),
        .push_i(b_push), .pop_i(b_pop), .err_clr_i(b_clr), .data_o(b_dout),
        .valid_o(b_valid), .full_o(b_full), .empty_o(b_empty), .afull_o(b_afull),
        .aempty_o(b_aempty), .level_o(b_level), .ovf_o(b_ovf), .udf_o(b_udf)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_flush = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0; a_din = '0;
        b_flush = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0; b_din = '0;
    endtask

    task automatic a_op(input logic push, input logic pop, input logic [7:0] din);
        a_push = push; a_pop = pop; a_din = din;
        tick();
        a_push = 1'b0; a_pop = 1'b0; a_din = '0;
    endtask

    task automatic b_op(input logic push, input logic pop, input logic [15:0] din);
        b_push = push; b_pop = pop; b_din = din;
        tick();
        b_push = 1'b0; b_pop = 1'b0; b_din = '0;
    endtask

    logic [7:0]  qa[$];
    logic [15:0] qb[$];

    initial begin
        idle_all();
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_empty",  32'(a_empty),  32'd1);
        check("rst_aempty", 32'(a_aempty), 32'd1);
        check("rst_full",   32'(a_full),   32'd0);
        check("rst_afull",  32'(a_afull),  32'd0);
        check("rst_level",  32'(a_level),  32'd0);
        check("rst_valid",  32'(a_valid),  32'd0);
        check("rst_b_data", 32'(b_dout),   32'd0);
        check("rst_b_valid",32'(b_valid),  32'd0);

        // T1: asynchronous reset mid-stream
        a_op(1'b0, 1'b1, 8'h00);
        check("t1_udf_set", 32'(a_udf), 32'd1);
        for (int i = 0; i < 5; i++) a_op(1'b1, 1'b0, 8'(i));
        check("t1_level5", 32'(a_level), 32'd5);
        #3 rst = 1'b1;
        #1;
        check("t1_async_level", 32'(a_level), 32'd0);
        check("t1_async_empty", 32'(a_empty), 32'd1);
        check("t1_async_udf",   32'(a_udf),   32'd0);
        check("t1_async_ovf",   32'(a_ovf),   32'd0);
        check("t1_async_valid", 32'(a_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // T2: fill, overflow, drain
        for (int i = 0; i < 64; i++) begin
            a_op(1'b1, 1'b0, 8'(i));
            if (i + 1 == 8)  check("t2_aempty_at8",  32'(a_aempty), 32'd1);
            if (i + 1 == 9)  check("t2_aempty_at9",  32'(a_aempty), 32'd0);
            if (i + 1 == 55) check("t2_afull_at55",  32'(a_afull),  32'd0);
            if (i + 1 == 56) check("t2_afull_at56",  32'(a_afull),  32'd1);
            if (i + 1 == 63) check("t2_full_at63",   32'(a_full),   32'd0);
        end
        check("t2_full",  32'(a_full),  32'd1);
        check("t2_level", 32'(a_level), 32'd64);
        a_op(1'b1, 1'b0, 8'hFF);
        check("t2_ovf",       32'(a_ovf),   32'd1);
        check("t2_ovf_level", 32'(a_level), 32'd64);
        for (int i = 0; i < 64; i++) begin
            check("t2_valid", 32'(a_valid), 32'd1);
            check("t2_data",  32'(a_dout),  32'(i));
            a_op(1'b0, 1'b1, 8'h00);
        end
        check("t2_drained_empty", 32'(a_empty), 32'd1);
        check("t2_drained_valid", 32'(a_valid), 32'd0);
        check("t2_udf_clear",     32'(a_udf),   32'd0);

        // T3: simultaneous push/pop at full and at empty (pointers have wrapped)
        for (int i = 0; i < 64; i++) a_op(1'b1, 1'b0, 8'(8'h40 + i));
        check("t3_head", 32'(a_dout), 32'h40);
        a_op(1'b1, 1'b1, 8'hAA);
        check("t3_full_level", 32'(a_level), 32'd64);
        check("t3_full_flag",  32'(a_full),  32'd1);
        check("t3_head_adv",   32'(a_dout),  32'h41);
        check("t3_no_ovf_chg", 32'(a_ovf),   32'd1);
        for (int i = 0; i < 64; i++) begin
            check("t3_data", 32'(a_dout), (i < 63) ? 32'(8'h41 + i) : 32'hAA);
            a_op(1'b0, 1'b1, 8'h00);
        end
        check("t3_empty", 32'(a_empty), 32'd1);
        a_op(1'b1, 1'b1, 8'h5C);
        check("t3_empty_udf",   32'(a_udf),   32'd1);
        check("t3_empty_level", 32'(a_level), 32'd1);
        check("t3_empty_data",  32'(a_dout),  32'h5C);
        a_op(1'b0, 1'b1, 8'h00);
        check("t3_pop_last", 32'(a_empty), 32'd1);

        // T4: flush has priority, keeps error flags
        for (int i = 0; i < 10; i++) a_op(1'b1, 1'b0, 8'(i));
        check("t4_level10", 32'(a_level), 32'd10);
        a_flush = 1'b1;
        a_op(1'b1, 1'b1, 8'h77);
        a_flush = 1'b0;
        check("t4_flush_level", 32'(a_level), 32'd0);
        check("t4_flush_empty", 32'(a_empty), 32'd1);
        check("t4_flush_valid", 32'(a_valid), 32'd0);
        check("t4_flush_ovf",   32'(a_ovf),   32'd1);
        check("t4_flush_udf",   32'(a_udf),   32'd1);
        a_clr = 1'b1;
        a_op(1'b0, 1'b1, 8'h00);
        a_clr = 1'b0;
        check("t4_clr_ovf",      32'(a_ovf), 32'd0);
        check("t4_clr_new_udf",  32'(a_udf), 32'd1);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        check("t4_clr_udf", 32'(a_udf), 32'd0);
        a_op(1'b1, 1'b0, 8'h33);
        check("t4_post_flush_data", 32'(a_dout), 32'h33);
        a_op(1'b0, 1'b1, 8'h00);

        // T5: registered-pop instance
        b_op(1'b1, 1'b0, 16'h1234);
        b_op(1'b1, 1'b0, 16'h5678);
        check("t5_push_valid", 32'(b_valid), 32'd0);
        check("t5_level2",     32'(b_level), 32'd2);
        b_op(1'b0, 1'b1, 16'h0);
        check("t5_pop1_valid", 32'(b_valid), 32'd1);
        check("t5_pop1_data",  32'(b_dout),  32'h1234);
        b_op(1'b0, 1'b1, 16'h0);
        check("t5_pop2_valid", 32'(b_valid), 32'd1);
        check("t5_pop2_data",  32'(b_dout),  32'h5678);
        tick();
        check("t5_idle_valid", 32'(b_valid), 32'd0);
        check("t5_hold_data",  32'(b_dout),  32'h5678);

        // T6: random traffic on both instances against queue models
        for (int c = 0; c < 10000; c++) begin
            int  pct;
            logic pa, ppa, pb, ppb, wa, ra, wb, rb;
            logic [7:0]  da;
            logic [15:0] db, popped_b;
            pct = (((c / 200) % 2) == 0) ? 70 : 30;
            pa  = ($urandom_range(0, 99) < pct);
            ppa = ($urandom_range(0, 99) >= pct);
            pb  = ($urandom_range(0, 99) < 50);
            ppb = ($urandom_range(0, 99) < 50);
            da  = 8'($urandom);
            db  = 16'($urandom);
            wa = pa && (qa.size() < 64 || ppa);
            ra = ppa && (qa.size() > 0);
            wb = pb && (qb.size() < 4 || ppb);
            rb = ppb && (qb.size() > 0);
            popped_b = rb ? qb[0] : 16'h0;
            a_push = pa; a_pop = ppa; a_din = da;
            b_push = pb; b_pop = ppb; b_din = db;
            tick();
            if (ra) void'(qa.pop_front());
            if (wa) qa.push_back(da);
            if (rb) void'(qb.pop_front());
            if (wb) qb.push_back(db);
            check("t6_a_level", 32'(a_level), 32'(qa.size()));
            check("t6_a_full",  32'(a_full),  32'(qa.size() == 64));
            check("t6_a_empty", 32'(a_empty), 32'(qa.size() == 0));
            if (qa.size() > 0) check("t6_a_data", 32'(a_dout), 32'(qa[0]));
            check("t6_b_level", 32'(b_level), 32'(qb.size()));
            check("t6_b_full",  32'(b_full),  32'(qb.size() == 4));
            check("t6_b_empty", 32'(b_empty), 32'(qb.size() == 0));
            check("t6_b_valid", 32'(b_valid), 32'(rb));
            if (rb) check("t6_b_data", 32'(b_dout), 32'(popped_b));
        end
        idle_all();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
